// File: rtl/garage_door_input_cond_pkg.sv
// Shared definitions for the garage door input conditioning block and the door FSM.
// Holds door state encodings, default cycle counts and the debounce counter width.
package garage_door_input_cond_pkg;

    typedef enum logic [1:0] {
        DOOR_IDLE      = 2'b00,
        DOOR_MOVING_UP = 2'b01,
        DOOR_MOVING_DN = 2'b10
    } door_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 8;
    localparam int DEF_LOCKOUT_CYCLES  = 16;
    localparam int DEF_STUCK_CYCLES    = 1024;
    localparam int DB_CNT_W            = 8;

endpackage

// File: rtl/garage_door_debounce.sv
// Two-flop synchronizer followed by a stability-count debouncer for one raw level.
// The output follows the synchronized level only after DEBOUNCE_CYCLES consecutive differing samples.
module garage_door_debounce
    import garage_door_input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_raw,
    output logic o_level
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                r_s1;
    logic                r_s2;
    logic                r_level;
    logic [DB_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            // A sample matching the current output (including any reversal) restarts the count.
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + DB_CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/garage_door_input_cond.sv
// Conditions the wall button and limit switches for the door FSM: debounce, activate pulse with
// lockout, limit fault flag. Optional stuck-button detector enabled by GD_STUCK_DETECT_EN.
module garage_door_input_cond
    import garage_door_input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
    parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
    input  logic clk,
    input  logic nrst,
    input  logic btn_raw,
    input  logic up_sw_raw,
    input  logic dn_sw_raw,
    output logic activate,
    output logic up_limit,
    output logic dn_limit,
    output logic sw_fault,
    output logic btn_stuck
);

    localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT_CYCLES);

    logic       w_btn_db;
    logic       w_up_db;
    logic       w_dn_db;
    logic       w_rise;
    logic       w_fire;
    logic       w_stuck;

    logic       r_btn_db_d;
    logic [7:0] r_lockout;
    logic       r_activate;
    logic       r_sw_fault;

    garage_door_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
        .clk     (clk),
        .nrst    (nrst),
        .i_raw   (btn_raw),
        .o_level (w_btn_db)
    );

    garage_door_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk     (clk),
        .nrst    (nrst),
        .i_raw   (up_sw_raw),
        .o_level (w_up_db)
    );

    garage_door_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .clk     (clk),
        .nrst    (nrst),
        .i_raw   (dn_sw_raw),
        .o_level (w_dn_db)
    );

    // Lockout is judged on its registered value, so a rise on the cycle it hits zero is accepted.
    assign w_rise = w_btn_db & ~r_btn_db_d;
    assign w_fire = w_rise && (r_lockout == 8'd0) && !r_sw_fault && !w_stuck;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_btn_db_d <= 1'b0;
            r_lockout  <= 8'd0;
            r_activate <= 1'b0;
            r_sw_fault <= 1'b0;
        end else begin
            r_btn_db_d <= w_btn_db;
            r_activate <= w_fire;
            r_sw_fault <= w_up_db & w_dn_db;
            if (w_fire) begin
                r_lockout <= LOCK_LOAD;
            end else if (r_lockout != 8'd0) begin
                r_lockout <= r_lockout - 8'd1;
            end
        end
    end

`ifdef GD_STUCK_DETECT_EN
    localparam int                 STUCK_W   = $clog2(STUCK_CYCLES + 1);
    localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

    logic [STUCK_W-1:0] r_stuck_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_stuck_cnt <= '0;
        end else if (!w_btn_db) begin
            r_stuck_cnt <= '0;
        end else if (r_stuck_cnt != STUCK_MAX) begin
            r_stuck_cnt <= r_stuck_cnt + STUCK_W'(1);
        end
    end

    // Gated by the debounced level so the flag drops on the same edge the button releases.
    assign w_stuck = w_btn_db && (r_stuck_cnt == STUCK_MAX);
`else
    // Detector absent; legal thresholds are positive, so this is a constant 0.
    assign w_stuck = (STUCK_CYCLES < 1);
`endif

    assign activate  = r_activate;
    assign up_limit  = w_up_db;
    assign dn_limit  = w_dn_db;
    assign sw_fault  = r_sw_fault;
    assign btn_stuck = w_stuck;

endmodule
